// File: rtl/seq_alu.sv
// Registered execute-stage ALU with an iterative shift-add multiplier,
// a restoring divider and the HI/LO architectural registers.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00, OP_AND   = 5'h01, OP_XOR  = 5'h02, OP_SLL  = 5'h03,
    OP_SUB   = 5'h04, OP_OR    = 5'h05, OP_LUI  = 5'h06, OP_SRL  = 5'h07,
    OP_SRA   = 5'h0F, OP_MULT  = 5'h10, OP_MULTU = 5'h11, OP_DIV = 5'h12,
    OP_DIVU  = 5'h13, OP_MFHI  = 5'h14, OP_MFLO = 5'h15, OP_MTHI = 5'h16,
    OP_MTLO  = 5'h17
  } op_t;

  state_t             state, state_d;
  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   acc, mq, mb, a_q;
  logic               is_div, q_neg, r_neg, dz;

  logic               accept, multi, last, op_signed;
  logic [SHW-1:0]     sa;
  logic [WIDTH-1:0]   sc_r, ma_in, mb_in;
  logic               sc_hi_we, sc_lo_we;

  logic [WIDTH-1:0]   mul_add, step_acc, step_mq;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign busy     = (state == RUN);
  assign in_ready = ~busy;
  assign z        = ~|r;
  assign sa       = a[SHW-1:0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    accept    = in_valid && (state == IDLE);
    multi     = (op[4:2] == 3'b100);
    last      = (cnt == SHW'(WIDTH-1));
    op_signed = ~op[0];
    state_d   = state;
    case (state)
      IDLE:    if (accept && multi) state_d = RUN;
      RUN:     if (cancel || last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sc_r     = '0;
    sc_hi_we = 1'b0;
    sc_lo_we = 1'b0;
    case (op)
      OP_ADD:  sc_r = a + b;
      OP_SUB:  sc_r = a - b;
      OP_AND:  sc_r = a & b;
      OP_OR:   sc_r = a | b;
      OP_XOR:  sc_r = a ^ b;
      OP_LUI:  sc_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  sc_r = b << sa;
      OP_SRL:  sc_r = b >> sa;
      OP_SRA:  sc_r = $signed(b) >>> sa;
      OP_MFHI: sc_r = hi;
      OP_MFLO: sc_r = lo;
      OP_MTHI: begin sc_r = a; sc_hi_we = 1'b1; end
      OP_MTLO: begin sc_r = a; sc_lo_we = 1'b1; end
      default: sc_r = '0;
    endcase
  end

  // Signed operands iterate as magnitudes; result signs are applied on the last step.
  always_comb begin
    ma_in = (op_signed && a[WIDTH-1]) ? -a : a;
    mb_in = (op_signed && b[WIDTH-1]) ? -b : b;
  end

  // acc holds the product high half / partial remainder; mq holds the
  // multiplier / dividend, shifted out one bit per step.
  always_comb begin
    mul_add  = mq[0] ? mb : '0;
    mul_sum  = {1'b0, acc} + {1'b0, mul_add};
    div_sh   = {acc, mq[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, mb};
    if (is_div) begin
      if (!div_diff[WIDTH+1]) begin
        step_acc = div_diff[WIDTH-1:0];
        step_mq  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_sh[WIDTH-1:0];
        step_mq  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_mq  = {mul_sum[0], mq[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = {step_acc, step_mq};
    prod_fix = q_neg ? -prod : prod;
    if (is_div) begin
      if (dz) begin
        fin_lo = '1;
        fin_hi = a_q;
      end else begin
        fin_lo = q_neg ? -step_mq : step_mq;
        fin_hi = r_neg ? -step_acc : step_acc;
      end
    end else begin
      {fin_hi, fin_lo} = prod_fix;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r         <= '0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      acc       <= '0;
      mq        <= '0;
      mb        <= '0;
      a_q       <= '0;
      is_div    <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (multi) begin
            cnt    <= '0;
            acc    <= '0;
            mq     <= ma_in;
            mb     <= mb_in;
            a_q    <= a;
            is_div <= op[1];
            q_neg  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg  <= op_signed & a[WIDTH-1];
            dz     <= (b == '0);
          end else begin
            r         <= sc_r;
            out_valid <= 1'b1;
            if (sc_hi_we) hi <= a;
            if (sc_lo_we) lo <= a;
          end
        end
      end else if (cancel) begin
        cnt <= '0;
      end else begin
        acc <= step_acc;
        mq  <= step_mq;
        cnt <= cnt + SHW'(1);
        if (last) begin
          cnt       <= '0;
          hi        <= fin_hi;
          lo        <= fin_lo;
          r         <= fin_lo;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
